// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: ALU control codes and CDB entry type shared by the execute unit and ALU controller
package alu_exec_pkg;
  localparam int ALU_XLEN  = 32;
  localparam int ALU_TAG_W = 5;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1111;
  typedef struct packed {
    logic [ALU_TAG_W-1:0] tag;
    logic [ALU_XLEN-1:0]  data;
    logic                 illegal;
  } cdb_entry_t;
endpackage

// File: rtl/alu_exec_obuf.sv
// alu_exec_obuf: FIFO of CDB entries holding results until the CDB arbiter grants a broadcast
module alu_exec_obuf
  import alu_exec_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t din,
  output cdb_entry_t dout,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);
  cdb_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset: only entries below count are ever observed
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: one-stage integer execute with buffered CDB broadcast; optional flush via ALU_EXEC_FLUSH_EN
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN       = ALU_XLEN,
  parameter int TAG_W      = ALU_TAG_W,
  parameter int OBUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_alu_ctrl,
  input  logic [XLEN-1:0]  issue_src_a,
  input  logic [XLEN-1:0]  issue_src_b,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_data,
  output logic             cdb_illegal,
`ifdef ALU_EXEC_FLUSH_EN
  input  logic             flush,
`endif
  output logic             busy
);
  localparam int SHW = $clog2(XLEN);
  localparam int AW  = $clog2(OBUF_DEPTH);
  logic             e_valid;
  logic [3:0]       e_ctrl;
  logic [XLEN-1:0]  e_a, e_b, e_res;
  logic [TAG_W-1:0] e_tag;
  logic             e_ill, e_move, accept, pop, full, empty, flush_i;
  logic [AW:0]      count;
  cdb_entry_t       head, e_entry;
`ifdef ALU_EXEC_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif
  assign pop         = !empty && cdb_grant;
  assign e_move      = e_valid && (!full || pop);
  assign issue_ready = !e_valid || e_move;
  assign accept      = issue_valid && issue_ready;
  assign busy        = e_valid || count != '0;
  assign cdb_req     = !empty;
  assign cdb_tag     = empty ? '0 : head.tag;
  assign cdb_data    = empty ? '0 : head.data;
  assign cdb_illegal = !empty && head.illegal;
  assign e_entry     = '{tag: e_tag, data: e_res, illegal: e_ill};
  // execute stage: undefined codes produce zero and are flagged illegal
  always_comb begin
    e_res = e_ctrl == ALU_ADD  ? e_a + e_b :
            e_ctrl == ALU_SUB  ? e_a - e_b :
            e_ctrl == ALU_XOR  ? e_a ^ e_b :
            e_ctrl == ALU_OR   ? e_a | e_b :
            e_ctrl == ALU_SRA  ? XLEN'($signed(e_a) >>> e_b[SHW-1:0]) :
            e_ctrl == ALU_PASS ? e_b : '0;
    e_ill = !(e_ctrl == ALU_ADD || e_ctrl == ALU_SUB || e_ctrl == ALU_XOR ||
              e_ctrl == ALU_OR || e_ctrl == ALU_SRA || e_ctrl == ALU_PASS);
  end
  // E register: capture on accept, drain into buffer on move, clear on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_ctrl  <= '0;
      e_a     <= '0;
      e_b     <= '0;
      e_tag   <= '0;
    end else if (flush_i) begin
      e_valid <= 1'b0;
    end else if (accept) begin
      e_valid <= 1'b1;
      e_ctrl  <= issue_alu_ctrl;
      e_a     <= issue_src_a;
      e_b     <= issue_src_b;
      e_tag   <= issue_tag;
    end else if (e_move) begin
      e_valid <= 1'b0;
    end
  end
  alu_exec_obuf #(.DEPTH(OBUF_DEPTH)) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_i),
    .push  (e_move),
    .pop   (pop),
    .din   (e_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (directed values, backpressure, streaming, reset)
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [3:0]  issue_alu_ctrl = '0;
  logic [31:0] issue_src_a = '0, issue_src_b = '0;
  logic [4:0]  issue_tag = '0;
  logic        cdb_req, cdb_grant = 1'b0, cdb_illegal, busy;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
`ifdef ALU_EXEC_FLUSH_EN
  logic        flush = 1'b0;
`endif
  int tests = 0, fails = 0;
  typedef struct {logic [4:0] tag; logic [31:0] data; logic ill;} exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_alu_ctrl(issue_alu_ctrl), .issue_src_a(issue_src_a),
    .issue_src_b(issue_src_b), .issue_tag(issue_tag),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_illegal(cdb_illegal),
`ifdef ALU_EXEC_FLUSH_EN
    .flush(flush),
`endif
    .busy(busy)
  );

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    exp_t e;
    e.tag = t;
    e.ill = 1'b0;
    case (c)
      4'b0010: e.data = a + b;
      4'b0110: e.data = a - b;
      4'b0011: e.data = a ^ b;
      4'b0001: e.data = a | b;
      4'b0111: e.data = $signed(a) >>> b[4:0];
      4'b1111: e.data = b;
      default: begin e.data = 32'h0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // scoreboard: pop and compare on broadcast, then push on accept
  always @(negedge clk) begin
    if (rst_n) begin
      if (cdb_req && cdb_grant) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected tag=%0d data=%h with empty scoreboard", cdb_tag, cdb_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({cdb_tag, cdb_data, cdb_illegal} !== {e.tag, e.data, e.ill}) begin
            fails++;
            $display("FAIL sb_result got tag=%0d data=%h ill=%b exp tag=%0d data=%h ill=%b",
                     cdb_tag, cdb_data, cdb_illegal, e.tag, e.data, e.ill);
          end
        end
      end
      if (!cdb_req) begin
        tests++;
        if ({cdb_tag, cdb_data, cdb_illegal} !== 38'h0) begin
          fails++;
          $display("FAIL idle_zero got tag=%0d data=%h ill=%b exp 0", cdb_tag, cdb_data, cdb_illegal);
        end
      end
      if (issue_valid && issue_ready)
        exp_q.push_back(model(issue_alu_ctrl, issue_src_a, issue_src_b, issue_tag));
    end
  end

  task automatic set_issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    issue_valid = 1'b1; issue_alu_ctrl = c; issue_src_a = a; issue_src_b = b; issue_tag = t;
  endtask

  task automatic do_issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    logic ok;
    int n = 0;
    set_issue(c, a, b, t);
    do begin
      @(negedge clk); ok = issue_ready;
      @(posedge clk); #2; n++;
    end while (!ok && n < 50);
    issue_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL issue_timeout tag=%0d never accepted", t);
    end
  endtask

  task automatic drain();
    int n = 0;
    cdb_grant = 1'b1;
    while (busy && n < 100) begin @(posedge clk); #2; n++; end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain busy=%b pending=%0d exp busy=0 pending=0", busy, exp_q.size());
    end
    @(posedge clk); #2;
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if ({cdb_req, cdb_tag, cdb_data, cdb_illegal, busy, issue_ready} !== {1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL %s req=%b tag=%0d data=%h ill=%b busy=%b ready=%b exp 0/0/0/0/0/1",
               name, cdb_req, cdb_tag, cdb_data, cdb_illegal, busy, issue_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    check_reset_outputs("reset_state");
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_add();
    cdb_grant = 1'b1;
    do_issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd3);
    @(negedge clk);
    tests++;
    if (cdb_req !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL add_e_stage req=%b busy=%b exp req=0 busy=1", cdb_req, busy);
    end
    @(negedge clk);
    tests++;
    if ({cdb_req, cdb_tag, cdb_data, cdb_illegal} !== {1'b1, 5'd3, 32'h8000_0000, 1'b0}) begin
      fails++;
      $display("FAIL add_broadcast req=%b tag=%0d data=%h ill=%b exp 1/3/80000000/0", cdb_req, cdb_tag, cdb_data, cdb_illegal);
    end
    @(negedge clk);
    tests++;
    if (cdb_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL add_popped req=%b busy=%b exp 0/0", cdb_req, busy);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_ops();
    logic [3:0]  c [7] = '{4'b0111, 4'b0110, 4'b0011, 4'b0001, 4'b1111, 4'b0100, 4'b1000};
    logic [31:0] a [7] = '{32'h8000_0010, 32'h0, 32'hF0F0_1234, 32'h0000_00F0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h5};
    logic [31:0] b [7] = '{32'h24, 32'h1, 32'h0FF0_FFFF, 32'h0F00_000F, 32'hABCD_E000, 32'h1, 32'h6};
    logic [31:0] d [7] = '{32'hF800_0001, 32'hFFFF_FFFF, 32'hFF00_EDCB, 32'h0F00_00FF, 32'hABCD_E000, 32'h0, 32'h0};
    logic        il[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0]  t [7] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd7, 5'd31};
    cdb_grant = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_issue(c[i], a[i], b[i], t[i]);
      @(negedge clk); @(negedge clk);
      tests++;
      if ({cdb_req, cdb_tag, cdb_data, cdb_illegal} !== {1'b1, t[i], d[i], il[i]}) begin
        fails++;
        $display("FAIL op_%0d req=%b tag=%0d data=%h ill=%b exp 1/%0d/%h/%b",
                 i, cdb_req, cdb_tag, cdb_data, cdb_illegal, t[i], d[i], il[i]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_backpressure();
    cdb_grant = 1'b0;
    for (int i = 1; i <= 3; i++) do_issue(4'b0010, 32'(i * 100), 32'(i), 5'(i));
    set_issue(4'b0110, 32'd400, 32'd4, 5'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (issue_ready !== 1'b0 || cdb_req !== 1'b1 || cdb_tag !== 5'd1) begin
        fails++;
        $display("FAIL bp_full ready=%b req=%b tag=%0d exp 0/1/1", issue_ready, cdb_req, cdb_tag);
      end
      @(posedge clk); #2;
    end
    cdb_grant = 1'b1;
    @(negedge clk);
    tests++;
    if (issue_ready !== 1'b1) begin
      fails++; $display("FAIL bp_pop_ready ready=%b exp 1", issue_ready);
    end
    @(posedge clk); #2;
    issue_valid = 1'b0;
    drain();
  endtask

  task automatic test_full_stream();
    cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) do_issue(4'b0011, $urandom, $urandom, 5'(16 + i));
    cdb_grant = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_issue(4'($urandom_range(0, 15)), $urandom, $urandom, 5'(i));
      @(negedge clk);
      tests++;
      if (issue_ready !== 1'b1 || cdb_req !== 1'b1) begin
        fails++; $display("FAIL full_stream_%0d ready=%b req=%b exp 1/1", i, issue_ready, cdb_req);
      end
      @(posedge clk); #2;
    end
    issue_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    cdb_grant = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_issue(i[0] ? 4'b0111 : 4'b0110, $urandom, $urandom, 5'(i + 8));
      @(negedge clk);
      tests++;
      if (issue_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_%0d ready=%b exp 1", i, issue_ready);
      end
      @(posedge clk); #2;
    end
    issue_valid = 1'b0;
    drain();
  endtask

`ifdef ALU_EXEC_FLUSH_EN
  task automatic test_flush();
    cdb_grant = 1'b0;
    do_issue(4'b0010, 32'd1, 32'd1, 5'd20);
    do_issue(4'b0010, 32'd2, 32'd2, 5'd21);
    set_issue(4'b0010, 32'd3, 32'd3, 5'd22);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; issue_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tests++;
    if (cdb_req !== 1'b0 || busy !== 1'b0 || issue_ready !== 1'b1) begin
      fails++; $display("FAIL flush req=%b busy=%b ready=%b exp 0/0/1", cdb_req, busy, issue_ready);
    end
    @(posedge clk); #2;
    drain();
  endtask
`endif

  task automatic test_reset_midstream();
    cdb_grant = 1'b0;
    do_issue(4'b0001, 32'h10, 32'h01, 5'd25);
    set_issue(4'b0001, 32'h20, 32'h02, 5'd26);
    #1 rst_n = 1'b0;
    #1 issue_valid = 1'b0;
    exp_q.delete();
    check_reset_outputs("reset_midstream");
    @(posedge clk); #2; rst_n = 1'b1;
    cdb_grant = 1'b1;
    do_issue(4'b0010, 32'd40, 32'd2, 5'd27);
    @(negedge clk); @(negedge clk);
    tests++;
    if ({cdb_req, cdb_tag, cdb_data} !== {1'b1, 5'd27, 32'd42}) begin
      fails++; $display("FAIL post_reset req=%b tag=%0d data=%h exp 1/27/0000002a", cdb_req, cdb_tag, cdb_data);
    end
    @(posedge clk); #2;
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_backpressure();
    test_full_stream();
    test_back_to_back();
`ifdef ALU_EXEC_FLUSH_EN
    test_flush();
`endif
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
